// File: rtl/cam_fb_pkg.sv
//==============================================================
// cam_fb_pkg: shared types and defaults for the camera frame-buffer path.
// Revision: 1.0
//==============================================================
`default_nettype none
package cam_fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cam_state_e;

  localparam int FB_WIDTH_DEFAULT  = 240;
  localparam int FB_HEIGHT_DEFAULT = 320;

  typedef logic [15:0] rgb565_t;

  // Wrapping increment for a phase counter of modulus n (n <= 4).
  function automatic logic [1:0] phase_inc(input logic [1:0] ph, input int n);
    return (int'(ph) >= n - 1) ? 2'd0 : ph + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cam_fb_writer_decim_phase.sv
//==============================================================
// decim_phase: mod-N phase counter with restart/clear/step controls.
// Revision: 1.0
//==============================================================
`default_nettype none
module decim_phase
  import cam_fb_pkg::*;
#(
  parameter int N = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       restart_i,
  input  logic       clear_i,
  input  logic       step_i,
  output logic [1:0] phase_o
);

  logic [1:0] phase_q;
  logic [1:0] phase_d;

  // restart_i marks the current item as phase 0; clear_i forces the next one to 0.
  assign phase_o = restart_i ? 2'd0 : phase_q;

  always_comb begin
    phase_d = phase_q;
    if (en_i) begin
      if (clear_i)     phase_d = 2'd0;
      else if (step_i) phase_d = phase_inc(phase_o, N);
      else             phase_d = phase_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) phase_q <= 2'd0;
    else       phase_q <= phase_d;
  end

endmodule
`default_nettype wire

// File: rtl/cam_fb_writer.sv
//==============================================================
// cam_fb_writer: camera pixel stream -> frame-buffer write port.
// Define CAM_FB_ROTATE_EN to store the image rotated 90 degrees clockwise.
// Revision: 1.0
//==============================================================
`default_nettype none
module cam_fb_writer
  import cam_fb_pkg::*;
#(
  parameter int FB_WIDTH  = FB_WIDTH_DEFAULT,
  parameter int FB_HEIGHT = FB_HEIGHT_DEFAULT,
  parameter int DECIM_H   = 1,
  parameter int DECIM_V   = 1,
  parameter int ADDR_W    = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              capture_in,
  input  logic              pixel_valid_in,
  input  logic [15:0]       pixel_data_in,
  input  logic              sof_in,
  input  logic              eol_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic [15:0]       data_out,
  output logic              we_out,
  output logic              frame_done_out,
  output logic              busy_out
);

`ifdef CAM_FB_ROTATE_EN
  localparam int                c_LIM_X   = FB_HEIGHT;
  localparam int                c_LIM_Y   = FB_WIDTH;
  localparam logic [ADDR_W-1:0] c_ORIGIN  = ADDR_W'(FB_WIDTH - 1);
  localparam logic [ADDR_W-1:0] c_PX_STEP = ADDR_W'(FB_WIDTH);
`else
  localparam int                c_LIM_X   = FB_WIDTH;
  localparam int                c_LIM_Y   = FB_HEIGHT;
  localparam logic [ADDR_W-1:0] c_ORIGIN  = '0;
  localparam logic [ADDR_W-1:0] c_PX_STEP = ADDR_W'(1);
`endif
  localparam logic [10:0] c_LIM_X11 = 11'(c_LIM_X);
  localparam logic [9:0]  c_LIM_Y10 = 10'(c_LIM_Y);
  localparam logic [9:0]  c_LAST_Y  = 10'(c_LIM_Y - 1);

  cam_state_e        state_q;
  logic              we_q, done_q, busy_q;
  logic [ADDR_W-1:0] waddr_q;
  rgb565_t           wdata_q;

  logic [10:0]       bx_q, bx_d;
  logic [9:0]        by_q, by_d;
  logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d;

  logic [1:0]        w_ph_h, w_ph_v;
  logic              w_sof, w_eol, w_keep, w_in_x, w_in_y, w_wr_ok, w_row_end, w_last_row;
  logic [10:0]       w_bx;
  logic [9:0]        w_by;
  logic [ADDR_W-1:0] w_addr, w_base, w_base_next;

  assign w_sof = pixel_valid_in & sof_in;
  assign w_eol = pixel_valid_in & eol_in & ~sof_in;

  decim_phase #(.N(DECIM_H)) u_ph_h (
    .clk_i(clk_in), .rst_i(rst_in), .en_i(pixel_valid_in), .restart_i(w_sof),
    .clear_i(w_eol), .step_i(1'b1), .phase_o(w_ph_h)
  );

  decim_phase #(.N(DECIM_V)) u_ph_v (
    .clk_i(clk_in), .rst_i(rst_in), .en_i(pixel_valid_in), .restart_i(w_sof),
    .clear_i(1'b0), .step_i(w_eol), .phase_o(w_ph_v)
  );

  // A sof pixel sees freshly restarted coordinates, regardless of the registers.
  assign w_bx       = w_sof ? 11'd0 : bx_q;
  assign w_by       = w_sof ? 10'd0 : by_q;
  assign w_addr     = w_sof ? c_ORIGIN : addr_q;
  assign w_base     = w_sof ? c_ORIGIN : base_q;
  assign w_keep     = pixel_valid_in & (w_ph_h == 2'd0) & (w_ph_v == 2'd0);
  assign w_in_x     = w_bx < c_LIM_X11;
  assign w_in_y     = w_by < c_LIM_Y10;
  assign w_wr_ok    = w_keep & w_in_x & w_in_y;
  assign w_row_end  = w_eol & (w_ph_v == 2'd0);
  assign w_last_row = w_row_end & (w_by == c_LAST_Y);

`ifdef CAM_FB_ROTATE_EN
  assign w_base_next = w_base - ADDR_W'(1);
`else
  assign w_base_next = w_base + ADDR_W'(FB_WIDTH);
`endif

  // bx/by saturate at the clip limit and the base stops at the last row, so nothing wraps.
  always_comb begin
    bx_d   = bx_q;
    by_d   = by_q;
    addr_d = addr_q;
    base_d = base_q;
    if (pixel_valid_in) begin
      bx_d   = w_bx;
      by_d   = w_by;
      base_d = w_base;
      addr_d = w_addr;
      if (w_eol) begin
        bx_d = 11'd0;
        if (w_row_end && w_in_y) begin
          by_d = w_by + 10'd1;
          if (w_by != c_LAST_Y) base_d = w_base_next;
        end
        addr_d = base_d;
      end else begin
        if ((w_ph_h == 2'd0) && w_in_x) bx_d = w_bx + 11'd1;
        if (w_wr_ok) addr_d = w_addr + c_PX_STEP;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bx_q   <= '0;
      by_q   <= '0;
      addr_q <= '0;
      base_q <= '0;
    end else begin
      bx_q   <= bx_d;
      by_q   <= by_d;
      addr_q <= addr_d;
      base_q <= base_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (w_wr_ok) begin
        waddr_q <= w_addr;
        wdata_q <= pixel_data_in;
      end
      case (state_q)
        ST_IDLE: begin
          if (capture_in) begin
            state_q <= ST_ARMED;
            busy_q  <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (!capture_in) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (w_sof) begin
            state_q <= ST_CAPTURE;
            we_q    <= w_wr_ok;
          end
        end
        ST_CAPTURE: begin
          if (w_sof) begin
            // Short frame: close it; the same sof may open the next one.
            done_q <= 1'b1;
            if (capture_in) begin
              we_q <= w_wr_ok;
            end else begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
            end
          end else begin
            we_q <= w_wr_ok;
            if (w_last_row) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          state_q <= capture_in ? ST_ARMED : ST_IDLE;
          busy_q  <= capture_in;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign addr_out       = waddr_q;
  assign data_out       = wdata_q;
  assign we_out         = we_q;
  assign frame_done_out = done_q;
  assign busy_out       = busy_q;

endmodule
`default_nettype wire
